// File: rtl/spi_slave_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_sync
//
// SPI responder implemented entirely on the system clock. SClk, MOSI and SS
// are oversampled through two-flop synchronizers. A third SClk/SS stage
// provides edge detection. Words are shifted out on MISO MSB first while the
// incoming word is shifted in. Back-to-back words are supported while SS
// stays low. All four SPI modes are selected by the SPI_MODE parameter.
//
// Parameters
//   DATA_WIDTH : word length in bits (>= 2)
//   SPI_MODE   : {CPOL, CPHA}. Bit 1 is the idle SClk level; bit 0 is the phase.
//
// Ports
//   Clk     in   system clock, rising edge
//   Reset   in   asynchronous, active-high reset
//   TxData  in   word to transmit, latched at each word load point
//   RxData  out  last complete received word
//   Done    out  one-Clk pulse when a word completes
//   Busy    out  high while selected (ACTIVE state)
//   SClk    in   SPI clock from the master (asynchronous to Clk)
//   MOSI    in   master-out data
//   MISO    out  slave-out data, high impedance when not selected
//   SS      in   active-low select
// ---------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int SPI_MODE   = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  Done,
    output logic                  Busy,
    input  logic                  SClk,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic                  SS
);

    localparam bit CPOL  = SPI_MODE[1];
    localparam bit CPHA  = SPI_MODE[0];
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Element [1] is the synchronized value. Element [2] is one cycle older
    // and is used only for edge detection.
    logic [2:0] sclk_sync;
    logic [2:0] ss_sync;
    logic [1:0] mosi_sync;

    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  ss_fall;
    logic                  ss_rise;
    logic                  leading_edge;
    logic                  trailing_edge;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  mosi_bit;

    logic [DATA_WIDTH-1:0] tx_latch;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [IDX_W-1:0]      rx_idx;
    logic [IDX_W-1:0]      tx_idx;
    logic [IDX_W-1:0]      tx_bit;
    logic                  first;

    // Input synchronizers. The SS stages reset high so that reset release
    // does not look like a select.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SClk};
            ss_sync   <= {ss_sync[1:0], SS};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    // Edge classification. The leading edge leaves the idle level and the
    // trailing edge returns to it. CPHA chooses which edge samples MOSI.
    always_comb begin
        sclk_rise     = sclk_sync[1] & ~sclk_sync[2];
        sclk_fall     = ~sclk_sync[1] & sclk_sync[2];
        ss_fall       = ~ss_sync[1] & ss_sync[2];
        ss_rise       = ss_sync[1] & ~ss_sync[2];
        leading_edge  = CPOL ? sclk_fall : sclk_rise;
        trailing_edge = CPOL ? sclk_rise : sclk_fall;
        sample_edge   = CPHA ? trailing_edge : leading_edge;
        shift_edge    = CPHA ? leading_edge : trailing_edge;
        mosi_bit      = mosi_sync[1];
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A select edge is the only thing that moves the FSM.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift datapath. SClk edges count only in ACTIVE, and a deselect takes
    // priority over any SClk edge seen in the same cycle. An abort clears the
    // partial word but leaves RxData alone.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx_latch <= '0;
            rx_shift <= '0;
            rx_idx   <= '0;
            tx_idx   <= '0;
            first    <= 1'b0;
            RxData   <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_latch <= TxData;
                        rx_shift <= '0;
                        rx_idx   <= '0;
                        tx_idx   <= '0;
                        first    <= CPHA;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        rx_shift <= '0;
                        rx_idx   <= '0;
                        tx_idx   <= '0;
                        first    <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_bit};
                        if (rx_idx == LAST_IDX) begin
                            RxData <= {rx_shift[DATA_WIDTH-2:0], mosi_bit};
                            Done   <= 1'b1;
                            rx_idx <= '0;
                        end else begin
                            rx_idx <= rx_idx + IDX_W'(1);
                        end
                    end else if (shift_edge) begin
                        // With CPHA=1 the first leading edge only arms the
                        // shifter, so the MSB stays on MISO for that bit.
                        if (first) begin
                            first <= 1'b0;
                        end else if (tx_idx == LAST_IDX) begin
                            tx_idx   <= '0;
                            tx_latch <= TxData;
                        end else begin
                            tx_idx <= tx_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    first <= 1'b0;
                end
            endcase
        end
    end

    // Output drive. MISO is released whenever the slave is not selected.
    assign tx_bit = LAST_IDX - tx_idx;
    assign Busy   = (state == ACTIVE);
    assign MISO   = (state == ACTIVE) ? tx_latch[tx_bit] : 1'bz;

endmodule

// File: tb/tb_spi_slave_sync.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_sync
//
// This bench instantiates four spi_slave_sync instances, one for each SPI
// mode. Each instance has its own SPI pins. A behavioural SPI master drives
// them. The expected slave words go into a scoreboard queue. A monitor pops
// that queue whenever a Done pulse appears.
// ---------------------------------------------------------------------------
module tb_spi_slave_sync;

    localparam int HALF = 8;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
    } exp_t;

    logic       Clk;
    logic       Reset;
    logic [3:0] sclk;
    logic [3:0] mosi;
    logic [3:0] ss;
    wire  [3:0] miso;
    logic [3:0] done;
    logic [3:0] busy;
    logic [7:0] tx_data [4];
    logic [7:0] rx_data [4];

    int   n_vec;
    int   n_miss;
    int   done_cnt [4];
    exp_t exp_q [$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(
            .DATA_WIDTH(8),
            .SPI_MODE  (g)
        ) dut (
            .Clk   (Clk),
            .Reset (Reset),
            .TxData(tx_data[g]),
            .RxData(rx_data[g]),
            .Done  (done[g]),
            .Busy  (busy[g]),
            .SClk  (sclk[g]),
            .MOSI  (mosi[g]),
            .MISO  (miso[g]),
            .SS    (ss[g])
        );
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // The behavioural master shifts nbits of mtx MSB first and returns what it
    // sampled on MISO.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] mtx,
                                 input int nbits, output logic [7:0] mrx);
        logic cpol;
        logic cpha;
        logic [2:0] b;
        cpol = m[1];
        cpha = m[0];
        mrx  = '0;
        for (int i = 0; i < nbits; i++) begin
            b = 3'(7 - i);
            if (!cpha) begin
                mosi[m] = mtx[b];
                wait_clk(HALF);
                sclk[m] = ~cpol;
                mrx[b]  = miso[m];
                wait_clk(HALF);
                sclk[m] = cpol;
            end else begin
                wait_clk(HALF);
                sclk[m] = ~cpol;
                mosi[m] = mtx[b];
                wait_clk(HALF);
                sclk[m] = cpol;
                mrx[b]  = miso[m];
            end
        end
    endtask

    task automatic pushExpected(input logic [1:0] m, input logic [7:0] d);
        exp_t e;
        e.mode = m;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // This task runs one full single-word exchange in mode m.
    task automatic runWord(input logic [1:0] m, input logic [7:0] mtx,
                           input logic [7:0] stx, input bit check_msb);
        logic [7:0] mrx;
        int base;
        base       = done_cnt[m];
        tx_data[m] = stx;
        pushExpected(m, mtx);
        ss[m] = 1'b0;
        wait_clk(HALF - 2);
        if (check_msb) begin
            checkOutput("MISO MSB before first edge", 32'(miso[m]), 32'(stx[7]));
        end
        wait_clk(2);
        checkOutput("Busy while selected", 32'(busy[m]), 1);
        applyStimulus(m, mtx, 8, mrx);
        wait_clk(HALF);
        ss[m] = 1'b1;
        wait_clk(4);
        checkOutput("Busy after SS rise", 32'(busy[m]), 0);
        checkOutput("master rx", 32'(mrx), 32'(stx));
        checkOutput("Done count", 32'(done_cnt[m] - base), 1);
    endtask

    // Scoreboard monitor. Every Done must match the oldest expected word, and
    // every Done must be a single cycle wide.
    initial begin
        logic [3:0] prev_done;
        logic [1:0] mi;
        exp_t e;
        prev_done = '0;
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        forever begin
            @(negedge Clk);
            for (int i = 0; i < 4; i++) begin
                mi = 2'(i);
                if (done[mi] === 1'b1) begin
                    done_cnt[mi]++;
                    checkOutput("Done width", 32'(prev_done[mi]), 0);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected Done", 32'(mi) + 32'd1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("Done mode", 32'(mi), 32'(e.mode));
                        checkOutput("slave RxData", 32'(rx_data[mi]), 32'(e.data));
                    end
                end
            end
            prev_done = done;
        end
    end

    initial begin
        logic [7:0] mrx1;
        logic [7:0] mrx2;
        logic [1:0] mi;
        int base;

        n_vec  = 0;
        n_miss = 0;
        Reset  = 1'b1;
        sclk   = 4'b1100;
        ss     = 4'b1111;
        mosi   = 4'b0000;
        for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
        wait_clk(3);
        Reset = 1'b0;
        wait_clk(4);

        $display("[TB] reset state");
        for (int i = 0; i < 4; i++) begin
            mi = 2'(i);
            checkOutput("reset RxData", 32'(rx_data[mi]), 0);
            checkOutput("reset Done", 32'(done[mi]), 0);
            checkOutput("reset Busy", 32'(busy[mi]), 0);
        end

        $display("[TB] single word, all modes");
        runWord(2'd3, 8'hA5, 8'hD6, 1'b0);
        runWord(2'd0, 8'h3C, 8'hC3, 1'b1);
        runWord(2'd1, 8'h3C, 8'hC3, 1'b0);
        runWord(2'd2, 8'h3C, 8'hC3, 1'b1);

        $display("[TB] back-to-back words");
        base       = done_cnt[3];
        tx_data[3] = 8'h9A;
        pushExpected(2'd3, 8'h12);
        pushExpected(2'd3, 8'h34);
        ss[3] = 1'b0;
        wait_clk(HALF);
        fork
            begin
                applyStimulus(2'd3, 8'h12, 8, mrx1);
                applyStimulus(2'd3, 8'h34, 8, mrx2);
            end
            begin
                for (int k = 0; k < 2000 && done[3] !== 1'b1; k++) wait_clk(1);
                tx_data[3] = 8'hBC;
            end
        join
        wait_clk(HALF);
        ss[3] = 1'b1;
        wait_clk(4);
        checkOutput("master rx word 1", 32'(mrx1), 'h9A);
        checkOutput("master rx word 2", 32'(mrx2), 'hBC);
        checkOutput("two-word Done count", 32'(done_cnt[3] - base), 2);
        checkOutput("RxData after two words", 32'(rx_data[3]), 'h34);

        $display("[TB] aborted word");
        base  = done_cnt[3];
        ss[3] = 1'b0;
        wait_clk(HALF);
        applyStimulus(2'd3, 8'hF0, 4, mrx1);
        wait_clk(HALF);
        ss[3] = 1'b1;
        wait_clk(2 * HALF);
        checkOutput("abort Done count", 32'(done_cnt[3] - base), 0);
        checkOutput("abort RxData held", 32'(rx_data[3]), 'h34);
        checkOutput("abort Busy", 32'(busy[3]), 0);
        runWord(2'd3, 8'h5A, 8'h77, 1'b0);

        $display("[TB] reset mid-word");
        tx_data[3] = 8'h00;
        ss[3]      = 1'b0;
        wait_clk(HALF);
        applyStimulus(2'd3, 8'hFF, 4, mrx1);
        Reset = 1'b1;
        wait_clk(1);
        checkOutput("reset mid-word RxData", 32'(rx_data[3]), 0);
        checkOutput("reset mid-word Done", 32'(done[3]), 0);
        checkOutput("reset mid-word Busy", 32'(busy[3]), 0);
        ss[3]   = 1'b1;
        sclk[3] = 1'b1;
        wait_clk(3);
        Reset = 1'b0;
        wait_clk(HALF);
        runWord(2'd3, 8'hFF, 8'h00, 1'b0);

        $display("[TB] SClk activity while deselected");
        base = done_cnt[3];
        for (int k = 0; k < 16; k++) begin
            wait_clk(HALF / 2);
            sclk[3] = ~sclk[3];
            mosi[3] = ~mosi[3];
        end
        wait_clk(HALF);
        checkOutput("idle Done count", 32'(done_cnt[3] - base), 0);
        checkOutput("idle Busy", 32'(busy[3]), 0);
        checkOutput("idle RxData held", 32'(rx_data[3]), 'hFF);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Clock-domain SPI slave: the responder end of the `spi_master` link, implemented as a synchronous block on the system clock instead of being clocked by `SClk`. It oversamples `SClk`, `MOSI` and `SS` through synchronizers and shifts `TxData` out on `MISO`, MSB first, while shifting `RxData` in. It pulses `Done` for one `Clk` cycle per completed word and supports back-to-back words while `SS` stays low. All four SPI modes are selected by parameter so it pairs with any `spi_master` configuration.

## Interface
- `DATA_WIDTH`, 8, word length in bits (≥2).
- `SPI_MODE`, 3, {CPOL,CPHA}: bit1 = idle `SClk` level, bit0 = phase.
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `TxData`  in  DATA_WIDTH  word to transmit; latched at each word load point.
- `RxData`  out  DATA_WIDTH  last complete received word.
- `Done`  out  1  one-cycle pulse when a word completes.
- `Busy`  out  1  high while selected (ACTIVE state).
- `SClk`  in  1  SPI clock from master (asynchronous to `Clk`).
- `MOSI`  in  1  master-out data.
- `MISO`  out  1  slave-out data; 1'bz when not selected.
- `SS`  in  1  active-low select.

## Operation
- `SClk`, `MOSI` and `SS` each pass through a 2-flop synchronizer. A third `SClk`/`SS` stage feeds edge detection.
- Leading edge is the first transition away from CPOL. Trailing edge is the return to CPOL.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other edge.
- States:
  - IDLE: `MISO`=z, `Busy`=0. A detected `SS` falling edge latches `TxData`, clears `RxIdx`/`TxIdx`, sets `First`=CPHA, and moves to ACTIVE.
  - ACTIVE: `MISO` = `TxLatch[DATA_WIDTH-1-TxIdx]`. Any detected `SS` rise returns to IDLE immediately.
- Sample edge:
  - `RxShift` <= {`RxShift`[W-2:0], `MOSI_sync`}, and `RxIdx`++.
  - When `RxIdx` = W-1: `RxData` <= {`RxShift`[W-2:0], `MOSI_sync`}, `Done` pulses, `RxIdx` <= 0.
- Shift edge:
  - If `First`=1: clear `First`, with no index change. For CPHA=1 this makes the first leading edge present the MSB.
  - Else if `TxIdx` = W-1: `TxIdx` <= 0 and `TxLatch` <= `TxData` (next word).
  - Else: `TxIdx`++.
- `SS` rising mid-word (abort):
  - No `Done`; `RxData` keeps its previous value.
  - Indices, `First` and `RxShift` are cleared and the state returns to IDLE.
- `SClk` edges while in IDLE are ignored.
- Reset mid-operation: immediately returns to IDLE with all registers at reset values.
- `SS` fall and an `SClk` edge detected in the same cycle: `SS` handling takes priority and the `SClk` edge is discarded.

## Timing
- Reset values: `RxData`=0, `Done`=0, `Busy`=0, `MISO`=z, state IDLE, all shift registers, indices and synchronizers 0. `SS` synchronizer stages reset to 1.
- Pin-to-detect latency: a pin edge captured at Clk edge n is acted on at edge n+2. `Done` and `RxData` update together at edge n+2 after the capture of the last sample edge.
- `MISO` changes at edge n+2 after the shift-edge capture. On `SS` fall it drives the MSB at edge n+2 after the `SS` capture.
- Constraint: each `SClk` high and low phase is ≥ 4 `Clk` periods. `SS` fall to first `SClk` edge is ≥ 4 `Clk` periods.
- `TxData` must be stable from `Done` until the word-boundary shift edge. For the first word, it must be stable at `SS` fall.
- `Done` is exactly 1 `Clk` wide. Successive `Done` pulses are separated by ≥ W·8 `Clk`.

## Test plan
- Mode 3, `spi_master` TxData 0xA5, slave TxData 0xD6 → slave `RxData`=0xA5, master RxData=0xD6, exactly one `Done` pulse, `Busy` falls after `SS` rises.
- Repeat for modes 0, 1, 2 with 0x3C/0xC3 → correct exchange in both directions in each mode, and `MISO`=MSB before the first `SClk` edge when CPHA=0.
- `SS` held low for two words: master 0x12 then 0x34; slave TxData 0x9A, updated to 0xBC after the first `Done` → two `Done` pulses, `RxData` 0x12 then 0x34, master receives 0x9A then 0xBC.
- `SS` raised after 4 `SClk` cycles, then a full 0x5A transfer → no `Done` on the aborted transfer, `RxData` retains its old value, next `RxData`=0x5A.
- `Reset` pulsed mid-word → all outputs return to reset values immediately, and the next full transfer (0xFF/0x00) completes correctly.
- `SClk` toggled 16 times with `SS` high → `MISO`=z, no `Done`, `Busy`=0, `RxData` unchanged.
